// File: rtl/wb_cpu_master_if.sv
// wb_cpu_master_if
//   Bundles the CPU request handshake from the UART packet decoder, the
//   Wishbone classic master/slave signals and the error status of
//   wb_cpu_master.
//   Parameters: dw (data width), aw (address width).
//   Modports:
//     master : the bus master (wb_cpu_master). It consumes the cpu_* request
//              and the wb_* slave response, and drives cpu_active,
//              cpu_data_rd, the wb_* master outputs, bus_error and timeout.
//     slave  : the opposite side (the decoder plus the Wishbone slave).
interface wb_cpu_master_if #(
  parameter int unsigned dw = 32,
  parameter int unsigned aw = 32
);
  // CPU request side
  logic          cpu_start;
  logic          cpu_write;
  logic [aw-1:0] cpu_address;
  logic [3:0]    cpu_selection;
  logic [dw-1:0] cpu_data_wr;
  logic [dw-1:0] cpu_data_rd;
  logic          cpu_active;

  // Wishbone master outputs
  logic [aw-1:0] wb_adr_o;
  logic [dw-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;

  // Wishbone slave response
  logic [dw-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;

  // Status
  logic          bus_error;
  logic          timeout;

  modport master (
    input  cpu_start, cpu_write, cpu_address, cpu_selection, cpu_data_wr,
    input  wb_dat_i, wb_ack_i, wb_err_i,
    output cpu_data_rd, cpu_active,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output bus_error, timeout
  );

  modport slave (
    output cpu_start, cpu_write, cpu_address, cpu_selection, cpu_data_wr,
    output wb_dat_i, wb_ack_i, wb_err_i,
    input  cpu_data_rd, cpu_active,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  bus_error, timeout
  );
endinterface

// File: rtl/wb_cpu_master.sv
// wb_cpu_master
//   Single-transfer Wishbone classic bus master. Turns one CPU request from
//   the UART packet decoder into one Wishbone read or write cycle, reports
//   slave errors and, optionally, bus timeouts.
//
//   Optional feature macro: WB_MASTER_TIMEOUT_EN
//     defined   : an 8-bit counter aborts a BUS phase after TIMEOUT_CYCLES
//                 cycles without ack/err (error exit, timeout=1).
//     undefined : BUS waits indefinitely, timeout is tied to 0.
//
//   Parameters: dw (data width), aw (address width),
//               TIMEOUT_CYCLES (1..255, used only with the timeout macro).
//   Ports:
//     clk  : clock
//     rst  : synchronous, active-high reset; abandons any bus cycle
//     bus  : wb_cpu_master_if.master
//            cpu_start/cpu_write/cpu_address/cpu_selection/cpu_data_wr in,
//            cpu_active/cpu_data_rd out, wb_* master outputs,
//            wb_dat_i/wb_ack_i/wb_err_i in, bus_error/timeout out.
//   All outputs are registered and reset to 0.
module wb_cpu_master #(
  parameter int unsigned dw             = 32,
  parameter int unsigned aw             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic             clk,
  input logic             rst,
  wb_cpu_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUS     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [dw-1:0] ERR_DATA = dw'(32'hDEADBEEF);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_cpu_master: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t        r_state, w_state;
  logic [aw-1:0] r_adr,   w_adr;
  logic [dw-1:0] r_dat,   w_dat;
  logic [3:0]    r_sel,   w_sel;
  logic          r_we,    w_we;
  logic          r_cyc,   w_cyc;
  logic          r_active, w_active;
  logic [dw-1:0] r_rd,    w_rd;
  logic          r_berr,  w_berr;
  logic          w_expire;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] r_cnt, w_cnt, w_cnt_inc;
  logic       r_tmo, w_tmo;

  // Expiry is judged on the incremented value, so the stb window is exactly
  // TIMEOUT_CYCLES BUS cycles long.
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_expire  = (r_state == S_BUS) && (w_cnt_inc == TMO_LIMIT);

  always_comb begin
    w_cnt = r_cnt;
    w_tmo = r_tmo;
    case (r_state)
      S_IDLE: begin
        if (bus.cpu_start) begin
          w_cnt = '0;
          w_tmo = 1'b0;
        end
      end
      S_BUS: begin
        // A response on the expiry cycle beats the timeout.
        if (!bus.wb_ack_i && !bus.wb_err_i) begin
          if (w_expire) w_tmo = 1'b1;
          else          w_cnt = w_cnt_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_cnt <= w_cnt;
      r_tmo <= w_tmo;
    end
  end

  assign bus.timeout = r_tmo;
`else
  assign w_expire    = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state  = r_state;
    w_adr    = r_adr;
    w_dat    = r_dat;
    w_sel    = r_sel;
    w_we     = r_we;
    w_cyc    = r_cyc;
    w_active = r_active;
    w_rd     = r_rd;
    w_berr   = r_berr;
    case (r_state)
      S_IDLE: begin
        if (bus.cpu_start) begin
          w_adr    = bus.cpu_address;
          w_dat    = bus.cpu_data_wr;
          w_sel    = bus.cpu_selection;
          w_we     = bus.cpu_write;
          w_cyc    = 1'b1;
          w_active = 1'b1;
          w_berr   = 1'b0;
          w_state  = S_BUS;
        end
      end
      S_BUS: begin
        // err has priority over ack; a timeout only counts with no ack.
        if (bus.wb_err_i || (w_expire && !bus.wb_ack_i)) begin
          w_cyc    = 1'b0;
          w_we     = 1'b0;
          w_active = 1'b0;
          w_berr   = 1'b1;
          if (!r_we) w_rd = ERR_DATA;
          w_state  = S_RELEASE;
        end else if (bus.wb_ack_i) begin
          w_cyc    = 1'b0;
          w_we     = 1'b0;
          w_active = 1'b0;
          if (!r_we) w_rd = bus.wb_dat_i;
          w_state  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Wait for the decoder to withdraw its request so a held cpu_start
        // cannot launch a second transfer.
        w_active = 1'b0;
        if (!bus.cpu_start) w_state = S_IDLE;
      end
      default: begin
        w_state  = S_IDLE;
        w_cyc    = 1'b0;
        w_we     = 1'b0;
        w_active = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_adr    <= '0;
      r_dat    <= '0;
      r_sel    <= '0;
      r_we     <= 1'b0;
      r_cyc    <= 1'b0;
      r_active <= 1'b0;
      r_rd     <= '0;
      r_berr   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_adr    <= w_adr;
      r_dat    <= w_dat;
      r_sel    <= w_sel;
      r_we     <= w_we;
      r_cyc    <= w_cyc;
      r_active <= w_active;
      r_rd     <= w_rd;
      r_berr   <= w_berr;
    end
  end

  assign bus.wb_adr_o    = r_adr;
  assign bus.wb_dat_o    = r_dat;
  assign bus.wb_sel_o    = r_sel;
  assign bus.wb_we_o     = r_we;
  assign bus.wb_cyc_o    = r_cyc;
  assign bus.wb_stb_o    = r_cyc;
  assign bus.cpu_active  = r_active;
  assign bus.cpu_data_rd = r_rd;
  assign bus.bus_error   = r_berr;

endmodule
